maxpool_window_reducer: RTL and testbench

//  Drives the pairwise sign-magnitude max/ReLU comparison as a sequential pooling engine.

---
 rtl/cnn_pkg.sv | 20 ++
 rtl/smag_relu_cmp.sv | 21 ++
 rtl/maxpool_window_reducer.sv | 107 ++++++++++
 tb/tb_maxpool_window_reducer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: sign-magnitude activation layout, ReLU helper
// and the pooling engine's state encoding.
package cnn_pkg;

  localparam int DATA_W      = 32;
  localparam int SIGN_BIT    = DATA_W - 1;
  localparam int MAG_W       = DATA_W - 1;
  localparam int DEFAULT_WIN = 4;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } pool_state_e;

  // Negative values, including negative zero, clamp to +0.
  function automatic logic [DATA_W-1:0] relu_smag(input logic [DATA_W-1:0] x);
    return x[SIGN_BIT] ? '0 : x;
  endfunction

endpackage

// File: rtl/smag_relu_cmp.sv
// Combinational sign-magnitude ReLU comparator: gt_o = relu(a) > relu(b), strictly,
// with relu(a) forwarded so the caller can load it without a second clamp.
module smag_relu_cmp
  import cnn_pkg::*;
#(
  parameter int W = cnn_pkg::DATA_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         gt_o,
  output logic [W-1:0] relu_a_o
);

  logic [W-1:0] relu_b;

  // After clamping both operands are non-negative, so the whole word orders by magnitude.
  assign relu_a_o = a_i[W-1] ? '0 : a_i;
  assign relu_b   = b_i[W-1] ? '0 : b_i;
  assign gt_o     = relu_a_o > relu_b;

endmodule

// File: rtl/maxpool_window_reducer.sv
// Sequential max-pool engine: folds each group of WIN sign-magnitude beats into one
// ReLU'd maximum plus the beat index that produced it, then holds it for the consumer.
module maxpool_window_reducer
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int WIN    = DEFAULT_WIN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [$clog2(WIN)-1:0]    out_idx,
  output logic                      out_zero
);

  localparam int IDX_W = $clog2(WIN);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(WIN - 1);

  pool_state_e       state_q, state_d;
  logic [IDX_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  best_q, best_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_zero_q, out_zero_d;

  logic              in_gt;
  logic [DATA_W-1:0] in_relu;
  logic [DATA_W-1:0] win_max;
  logic [IDX_W-1:0]  win_idx;

  smag_relu_cmp #(.W(DATA_W)) u_cmp (
    .a_i      (in_data),
    .b_i      (acc_q),
    .gt_o     (in_gt),
    .relu_a_o (in_relu)
  );

  // Strict compare keeps the earliest index on ties; acc starts at 0 so negatives never win.
  assign win_max = in_gt ? in_relu : acc_q;
  assign win_idx = in_gt ? count_q : best_q;

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_zero  = out_zero_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    best_d     = best_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_zero_d = out_zero_q;
    case (state_q)
      ACC: begin
        if (in_valid) begin
          if (count_q == LAST_BEAT) begin
            out_data_d = win_max;
            out_idx_d  = win_idx;
            out_zero_d = (win_max == '0);
            count_d    = '0;
            acc_d      = '0;
            best_d     = '0;
            state_d    = HOLD;
          end else begin
            acc_d   = win_max;
            best_d  = win_idx;
            count_d = count_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      count_q    <= '0;
      acc_q      <= '0;
      best_q     <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_zero_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      best_q     <= best_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_zero_q <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_maxpool_window_reducer.sv
// Self-checking bench for maxpool_window_reducer (WIN=4): directed scenarios plus
// randomized windows compared against a plain loop-based pooling model.
module tb_maxpool_window_reducer;

  localparam int DW  = 32;
  localparam int WN  = 4;
  localparam int IW  = 2;
  typedef logic [DW-1:0] win_t [WN];

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_zero;

  int n_checks;
  int n_fail;

  maxpool_window_reducer #(.DATA_W(DW), .WIN(WN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: clamp negatives to zero, keep the first strictly larger value.
  function automatic void ref_pool(input win_t w, output logic [DW-1:0] m,
                                   output int idx, output logic z);
    logic [DW-1:0] v;
    m = '0;
    idx = 0;
    for (int i = 0; i < WN; i++) begin
      v = w[i][DW-1] ? '0 : w[i];
      if (v > m) begin
        m = v;
        idx = i;
      end
    end
    z = (m == '0);
  endfunction

  // Presents one beat from a negedge and returns at the negedge after its handshake.
  task automatic send_beat(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL send_beat_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_window(input win_t w);
    for (int i = 0; i < WN; i++) send_beat(w[i]);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL reset_out_zero: got %0b want 1", out_zero); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_checks++; if (out_idx !== '0) begin n_fail++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send_beat(32'd5);
    send_beat(32'd9);
    send_beat(32'd3);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0b want 0", out_valid); end
    send_beat(32'd7);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    n_checks++; if (out_data !== 32'd9) begin n_fail++; $display("FAIL basic_data: got %0d want 9", out_data); end
    n_checks++; if (out_idx !== 2'd1) begin n_fail++; $display("FAIL basic_idx: got %0d want 1", out_idx); end
    n_checks++; if (out_zero !== 1'b0) begin n_fail++; $display("FAIL basic_zero: got %0b want 0", out_zero); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_bubble: in_ready got %0b want 0", in_ready); end
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_back: got %0b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %0b want 0", out_valid); end
  endtask

  task automatic test_negative;
    out_ready = 1'b0;
    send_window('{32'h8000_0005, 32'h8000_0001, 32'h8000_0000, 32'h8000_FFFF});
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL neg_valid: got %0b want 1", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL neg_data: got %h want 0", out_data); end
    n_checks++; if (out_idx !== 2'd0) begin n_fail++; $display("FAIL neg_idx: got %0d want 0", out_idx); end
    n_checks++; if (out_zero !== 1'b1) begin n_fail++; $display("FAIL neg_zero: got %0b want 1", out_zero); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_ties;
    send_window('{32'd4, 32'd8, 32'd8, 32'd2});
    n_checks++; if (out_data !== 32'd8) begin n_fail++; $display("FAIL tie_data: got %0d want 8", out_data); end
    n_checks++; if (out_idx !== 2'd1) begin n_fail++; $display("FAIL tie_idx: got %0d want 1", out_idx); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    send_window('{32'h8000_0009, 32'h0000_0003, 32'h8000_0004, 32'h0000_0001});
    n_checks++; if (out_data !== 32'd3) begin n_fail++; $display("FAIL signmag_data: got %0d want 3", out_data); end
    n_checks++; if (out_idx !== 2'd1) begin n_fail++; $display("FAIL signmag_idx: got %0d want 1", out_idx); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] held;
    send_window('{32'd1, 32'd50, 32'd2, 32'd3});
    held = out_data;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 32'd999 + c;
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold: valid=%0b ready=%0b want 1/0", out_valid, in_ready); end
      n_checks++; if (out_data !== held || out_data !== 32'd50 || out_idx !== 2'd1) begin n_fail++; $display("FAIL bp_stable: data=%0d idx=%0d want 50/1", out_data, out_idx); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    send_window('{32'd1, 32'd2, 32'd3, 32'd4});
    n_checks++; if (out_data !== 32'd4) begin n_fail++; $display("FAIL bp_next_data: got %0d want 4", out_data); end
    n_checks++; if (out_idx !== 2'd3) begin n_fail++; $display("FAIL bp_next_idx: got %0d want 3", out_idx); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midwindow;
    int seen;
    send_beat(32'd9);
    send_beat(32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_state: valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
    send_beat(32'd2);
    send_beat(32'd2);
    send_beat(32'd6);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stale: valid=%0b want 0", out_valid); end
    send_beat(32'd1);
    in_valid = 1'b0;
    n_checks++; if (out_data !== 32'd6 || out_idx !== 2'd2) begin n_fail++; $display("FAIL rst_mid_result: data=%0d idx=%0d want 6/2", out_data, out_idx); end
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_extra: %0d extra results, want 0", seen); end
  endtask

  task automatic test_random;
    win_t          w;
    logic [DW-1:0] em;
    int            ei;
    logic          ez;
    logic [DW-1:0] held;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < WN; i++) begin
        if ($urandom_range(0, 3) == 0) w[i] = $urandom;
        else w[i] = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 6))};
      end
      ref_pool(w, em, ei, ez);
      for (int i = 0; i < WN; i++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_beat(w[i]);
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want 1", t, out_valid); end
      n_checks++; if (out_data !== em || out_idx !== IW'(ei) || out_zero !== ez) begin
        n_fail++;
        $display("FAIL rnd_result[%0d]: got %h/%0d/%0b want %h/%0d/%0b", t, out_data, out_idx, out_zero, em, ei, ez);
      end
      held = out_data;
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_data !== held) begin n_fail++; $display("FAIL rnd_hold[%0d]: valid=%0b data=%h want 1/%h", t, out_valid, out_data, held); end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_release[%0d]: valid=%0b ready=%0b want 0/1", t, out_valid, in_ready); end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_negative();
    test_ties();
    test_backpressure();
    test_reset_midwindow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
